// File: rtl/transmitter.sv
// transmitter: DMA transmit engine. Polls a host ring of 64-byte slots, requests each
// pending slot from memory and streams the completion bytes into the PHY TX FIFO.
module transmitter (
    input  logic        sys_clk,
    input  logic        sys_rst,
    output logic [17:0] mst_din,
    input  logic        mst_full,
    output logic        mst_wr_en,
    input  logic [17:0] cpl_dout,
    input  logic        cpl_empty,
    output logic        cpl_rd_en,
    output logic [8:0]  phy_din,
    input  logic        phy_full,
    output logic        phy_wr_en,
    input  logic [7:0]  dma_status,
    input  logic [29:0] dma_addr_start,
    input  logic [29:0] dma_addr_end,
    input  logic [29:0] dma_addr_prod,
    output logic [29:0] dma_addr_cur,
    output logic [15:0] tx_frames,
    output logic [7:0]  tx_drops
);
    localparam logic [17:0] REQ_WORD0 = {2'b10, 16'h10ff};
    localparam logic [29:0] SLOT_STEP = 30'd16;

    typedef enum logic [3:0] {IDLE, REQ0, REQ1, REQ2, LEN, DATA, DRAIN, GAP, NEXT} state_t;

    state_t      state_reg;
    logic [15:0] hold_reg;
    logic        hold_valid_reg;
    logic        hold_hi_reg;
    logic [5:0]  byte_cnt_reg;
    logic [5:0]  len_reg;
    logic        rd_valid_reg;
    logic        eof_seen_reg;
    logic        dropped_reg;
    logic        fetch_ok;
    logic        status_unused;

    // Only one completion read in flight: a new strobe waits until the last word has landed.
    assign fetch_ok      = !cpl_rd_en && !rd_valid_reg && !cpl_empty;
    assign status_unused = ^{dma_status[7:1], cpl_dout[17]};

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_reg      <= IDLE;
            mst_din        <= 18'd0;
            mst_wr_en      <= 1'b0;
            cpl_rd_en      <= 1'b0;
            phy_din        <= 9'd0;
            phy_wr_en      <= 1'b0;
            dma_addr_cur   <= 30'd0;
            tx_frames      <= 16'd0;
            tx_drops       <= 8'd0;
            hold_reg       <= 16'd0;
            hold_valid_reg <= 1'b0;
            hold_hi_reg    <= 1'b1;
            byte_cnt_reg   <= 6'd0;
            len_reg        <= 6'd0;
            rd_valid_reg   <= 1'b0;
            eof_seen_reg   <= 1'b0;
            dropped_reg    <= 1'b0;
        end else begin
            mst_wr_en    <= 1'b0;
            cpl_rd_en    <= 1'b0;
            phy_wr_en    <= 1'b0;
            rd_valid_reg <= cpl_rd_en;

            case (state_reg)
                IDLE: begin
                    if (dma_addr_cur == 30'd0) begin
                        dma_addr_cur <= dma_addr_start;
                    end else if (dma_status[0] && dma_addr_cur != dma_addr_prod) begin
                        hold_valid_reg <= 1'b0;
                        hold_hi_reg    <= 1'b1;
                        byte_cnt_reg   <= 6'd0;
                        eof_seen_reg   <= 1'b0;
                        dropped_reg    <= 1'b0;
                        // Issue word 0 straight from the decision so requests follow at once.
                        if (!mst_full) begin
                            mst_wr_en <= 1'b1;
                            mst_din   <= REQ_WORD0;
                            state_reg <= REQ1;
                        end else begin
                            state_reg <= REQ0;
                        end
                    end
                end
                REQ0: if (!mst_full) begin
                    mst_wr_en <= 1'b1;
                    mst_din   <= REQ_WORD0;
                    state_reg <= REQ1;
                end
                REQ1: if (!mst_full) begin
                    mst_wr_en <= 1'b1;
                    mst_din   <= {2'b00, dma_addr_cur[29:14]};
                    state_reg <= REQ2;
                end
                REQ2: if (!mst_full) begin
                    mst_wr_en <= 1'b1;
                    mst_din   <= {2'b01, dma_addr_cur[13:0], 2'b00};
                    state_reg <= LEN;
                end
                LEN: begin
                    if (rd_valid_reg) begin
                        eof_seen_reg <= cpl_dout[16];
                        len_reg      <= cpl_dout[5:0];
                        if (cpl_dout[15:0] >= 16'd1 && cpl_dout[15:0] <= 16'd62) begin
                            state_reg <= DATA;
                        end else begin
                            dropped_reg <= 1'b1;
                            if (tx_drops != 8'hff)
                                tx_drops <= tx_drops + 8'd1;
                            state_reg <= DRAIN;
                        end
                    end else if (fetch_ok) begin
                        cpl_rd_en <= 1'b1;
                    end
                end
                DATA: begin
                    if (rd_valid_reg) begin
                        hold_reg       <= cpl_dout[15:0];
                        hold_valid_reg <= 1'b1;
                        hold_hi_reg    <= 1'b1;
                        if (cpl_dout[16])
                            eof_seen_reg <= 1'b1;
                    end else if (hold_valid_reg) begin
                        if (!phy_full) begin
                            phy_wr_en    <= 1'b1;
                            phy_din      <= {1'b1, hold_hi_reg ? hold_reg[15:8] : hold_reg[7:0]};
                            byte_cnt_reg <= byte_cnt_reg + 6'd1;
                            hold_hi_reg  <= !hold_hi_reg;
                            // Odd length: the unused low byte is simply dropped with the register.
                            if (!hold_hi_reg || byte_cnt_reg + 6'd1 == len_reg)
                                hold_valid_reg <= 1'b0;
                            if (byte_cnt_reg + 6'd1 == len_reg)
                                state_reg <= DRAIN;
                        end
                    end else if (fetch_ok) begin
                        cpl_rd_en <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (eof_seen_reg || (rd_valid_reg && cpl_dout[16]))
                        state_reg <= dropped_reg ? NEXT : GAP;
                    else if (fetch_ok)
                        cpl_rd_en <= 1'b1;
                end
                GAP: if (!phy_full) begin
                    phy_wr_en <= 1'b1;
                    phy_din   <= 9'h000;
                    tx_frames <= tx_frames + 16'd1;
                    state_reg <= NEXT;
                end
                NEXT: begin
                    if (dma_addr_cur == dma_addr_end)
                        dma_addr_cur <= dma_addr_start;
                    else
                        dma_addr_cur <= dma_addr_cur + SLOT_STEP;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule
